fpu_fpd_add_sched: RTL and testbench
====================================

# fpu_fpd_add_sched

Two-requester scheduler that shares one double-precision adder (`FpuFpD_Add`) between two FPU clients, such as the scalar FPU issue path and the FP compare/convert microsequencer. It accepts operations through valid/ready handshakes and arbitrates round-robin. It registers operands into the adder, waits a fixed settle latency, and returns the result with a tag to the requester that issued it. Only one operation is outstanding at a time.

## Interface
- `LAT`, default 2: adder settle cycles between operand latch and result capture; legal range 1..7.
- `TAGW`, default 4: width of the requester-supplied tag.
- `clk` in 1: sole clock; everything updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): requester N presents an operation.
- `reqN_ready` out 1: scheduler accepts requester N this cycle.
- `reqN_sub` in 1: 1 = srca−srcb, 0 = srca+srcb.
- `reqN_srca`, `reqN_srcb` in 64: IEEE double operands.
- `reqN_tag` in TAGW: opaque tag, echoed back.
- `rspN_valid` out 1: result for requester N is available.
- `rspN_ready` in 1: requester N consumes the result.
- `rspN_data` out 64: double result.
- `rspN_tag` out TAGW: tag of the completed operation.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant a requester: if only one `reqN_valid` is high, grant it. If both are high, grant the one not granted last. `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready` equals grant & IDLE and is combinational from `reqN_valid` and `last_grant`. At most one ready is high.
  - On handshake: latch srca, srcb, sub, tag and owner into operand registers; update `last_grant`; load cnt = LAT−1; go to EXEC.
- EXEC:
  - Adder is driven from the operand registers with `enable` = 1.
  - While cnt ≠ 0, decrement it.
  - When cnt = 0, capture adder dst into `res_q` and go to RESP.
- RESP:
  - `rsp<owner>_valid` = 1; `rsp<owner>_data` = `res_q`; `rsp<owner>_tag` = latched tag.
  - The non-owner `rsp_valid` stays 0.
  - Data and tag stay stable until `rsp<owner>_ready` is high at an edge; then go to IDLE.
- Result encoding is exactly what the adder produces: exact zero → +0; exponent overflow → ±Inf; underflow → +0. The scheduler never alters data.
- A request arriving while busy sees ready = 0 and must hold its valid and payload (AXI-style, no drop).
- Both `rspN` data/tag buses drive `res_q`/tag at all times. Only `valid` is qualified by owner.

## Timing
- Cycle 0: request handshake edge.
- Cycles 1..LAT: EXEC.
- Result is captured at the end of cycle LAT; `rsp_valid` rises in cycle LAT+1.
- Response handshake at the edge of cycle k → IDLE in cycle k+1, where the next request can be accepted.
- Best-case throughput is one operation per LAT+2 cycles. There is no request/response overlap.
- Reset values: `reqN_ready` = 0 while `reset_n` = 0. `rspN_valid` = 0, `rspN_data` = 0, `rspN_tag` = 0, `busy` = 0. State = IDLE, cnt = 0, `last_grant` = 1.
- Reset mid-operation (EXEC or RESP) abandons the operation with no response; the operation is not replayed.
- `rsp_ready` high while not in RESP is ignored.
- `rsp_ready` held high in RESP completes in the first RESP cycle.

## Structure
- Shared package `fpu_pkg`:
  - state enum `FPD_SCHED_IDLE/EXEC/RESP` (2 bits)
  - constants `FPD_POS_ZERO`, `FPD_ONE` = 64'h3FF0_0000_0000_0000
  - `FPD_LAT_MAX` = 7
- One sub-module: the shared `FpuFpD_Add` instance. Its srca/srcb/doSub come only from the operand registers, never from request ports directly.
- Counter width is 3 bits; LAT outside 1..7 is a parameter error that elaboration must fail on.

## Test plan
- req0 add, srca = 3FF0_0000_0000_0000 (1.0), srcb = 4000_0000_0000_0000 (2.0), tag 5, LAT = 2 → `rsp0_valid` in cycle 3, data 4008_0000_0000_0000, tag 5; `rsp1_valid` stays 0.
- req1 sub, 3.0 − 1.0 → `rsp1_data` 4000_0000_0000_0000. Then x − x with x = 4008… → data 0.
- Both valid out of reset → req0 served first, then req1 next IDLE; repeat with both valid → req0, req1 alternate.
- `rsp0_ready` low for 5 cycles → `rsp0_valid`, data and tag held constant; req1 valid meanwhile sees ready = 0 until the cycle after the rsp0 handshake.
- Overflow: 7FE0… + 7FE0… → 7FF0_0000_0000_0000.
- `reset_n` low in EXEC → next cycle all outputs at reset values, no response ever issued; the following request completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU scheduler types and double-precision constants
package fpu_pkg;

  typedef enum logic [1:0] {
    FPD_SCHED_IDLE = 2'd0,
    FPD_SCHED_EXEC = 2'd1,
    FPD_SCHED_RESP = 2'd2
  } fpd_sched_state_e;

  localparam logic [63:0] FPD_POS_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] FPD_ONE      = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] FPD_QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [10:0] FPD_EXP_MAX  = 11'h7FF;
  localparam int          FPD_LAT_MAX  = 7;

endpackage

// File: rtl/fpu_fpd_add_sched_add.sv
// rtl/fpu_fpd_add_sched_add.sv - combinational IEEE double adder, round-to-nearest-even
// Subnormal inputs read as zero; results below the normal range flush to +0.
module FpuFpD_Add
  import fpu_pkg::*;
(
  input  logic        enable,
  input  logic [63:0] srca,
  input  logic [63:0] srcb,
  input  logic        do_sub,
  output logic [63:0] dst
);

  logic        sa, sb, sl, ss, swap, rnd, a_nan, b_nan, a_inf, b_inf, sticky;
  logic [10:0] ea0, eb0, el, es, d;
  logic [52:0] ma0, mb0, ml, ms;
  logic [5:0]  dd, p, lz;
  logic [55:0] xa, xb0, xb, m;
  logic [56:0] s;
  logic [12:0] e, ef;
  logic [53:0] r54;
  logic [51:0] frac;
  logic [63:0] res;

  always_comb begin
    sa    = srca[63];
    sb    = srcb[63] ^ do_sub;
    ea0   = srca[62:52];
    eb0   = srcb[62:52];
    ma0   = (ea0 == 11'd0) ? 53'd0 : {1'b1, srca[51:0]};
    mb0   = (eb0 == 11'd0) ? 53'd0 : {1'b1, srcb[51:0]};
    a_inf = (ea0 == FPD_EXP_MAX) && (srca[51:0] == 52'd0);
    b_inf = (eb0 == FPD_EXP_MAX) && (srcb[51:0] == 52'd0);
    a_nan = (ea0 == FPD_EXP_MAX) && (srca[51:0] != 52'd0);
    b_nan = (eb0 == FPD_EXP_MAX) && (srcb[51:0] != 52'd0);

    // larger magnitude goes on the left so the difference never goes negative
    swap = {ea0, ma0} < {eb0, mb0};
    el   = swap ? eb0 : ea0;
    es   = swap ? ea0 : eb0;
    ml   = swap ? mb0 : ma0;
    ms   = swap ? ma0 : mb0;
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;

    d      = el - es;
    dd     = (d > 11'd56) ? 6'd56 : d[5:0];
    xa     = {ml, 3'b000};
    xb0    = {ms, 3'b000};
    sticky = |(xb0 & ~({56{1'b1}} << dd));
    xb     = (xb0 >> dd) | {55'd0, sticky};
    s      = (sl == ss) ? ({1'b0, xa} + {1'b0, xb}) : ({1'b0, xa} - {1'b0, xb});

    p = 6'd0;
    for (int i = 0; i < 57; i++) begin
      if (s[i]) p = i[5:0];
    end

    lz = 6'd0;
    if (s[56]) begin
      m = s[56:1] | {55'd0, s[0]};
      e = {2'b00, el} + 13'd1;
    end else begin
      lz = 6'd55 - p;
      m  = s[55:0] << lz;
      e  = {2'b00, el} - {7'd0, lz};
    end

    rnd = m[2] & (m[1] | m[0] | m[3]);
    r54 = {1'b0, m[55:3]} + {53'd0, rnd};
    if (r54[53]) begin
      frac = r54[52:1];
      ef   = e + 13'd1;
    end else begin
      frac = r54[51:0];
      ef   = e;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) res = FPD_QNAN;
    else if (a_inf)                                        res = {sa, FPD_EXP_MAX, 52'd0};
    else if (b_inf)                                        res = {sb, FPD_EXP_MAX, 52'd0};
    else if (s == 57'd0)                                   res = FPD_POS_ZERO;
    else if (ef[12] || (ef == 13'd0))                      res = FPD_POS_ZERO;
    else if (ef >= {2'b00, FPD_EXP_MAX})                   res = {sl, FPD_EXP_MAX, 52'd0};
    else                                                   res = {sl, ef[10:0], frac};

    dst = enable ? res : FPD_POS_ZERO;
  end

endmodule

// File: rtl/fpu_fpd_add_sched.sv
// rtl/fpu_fpd_add_sched.sv - round-robin scheduler sharing one double adder between two requesters
module fpu_fpd_add_sched
  import fpu_pkg::*;
#(
  parameter int LAT  = 2,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_sub,
  input  logic [63:0]     req0_srca,
  input  logic [63:0]     req0_srcb,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_sub,
  input  logic [63:0]     req1_srca,
  input  logic [63:0]     req1_srcb,
  input  logic [TAGW-1:0] req1_tag,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [63:0]     rsp0_data,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [63:0]     rsp1_data,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);

  if (LAT < 1 || LAT > FPD_LAT_MAX) begin : g_bad_lat
    $error("fpu_fpd_add_sched: LAT must be within 1..7");
  end

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  fpd_sched_state_e state, state_nxt;
  logic [2:0]      cnt;
  logic            last_grant, owner, sub_q, grant0, grant1;
  logic [63:0]     srca_q, srcb_q, res_q, add_dst;
  logic [TAGW-1:0] tag_q;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      FPD_SCHED_IDLE: begin
        // on a tie the requester not served last wins
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        if (grant0 | grant1) state_nxt = FPD_SCHED_EXEC;
      end
      FPD_SCHED_EXEC: if (cnt == 3'd0) state_nxt = FPD_SCHED_RESP;
      FPD_SCHED_RESP: if (owner ? rsp1_ready : rsp0_ready) state_nxt = FPD_SCHED_IDLE;
      default:        state_nxt = FPD_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FPD_SCHED_IDLE;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      sub_q      <= 1'b0;
      srca_q     <= FPD_POS_ZERO;
      srcb_q     <= FPD_POS_ZERO;
      tag_q      <= '0;
      res_q      <= FPD_POS_ZERO;
    end else begin
      state <= state_nxt;
      if (state == FPD_SCHED_IDLE && (grant0 | grant1)) begin
        owner      <= grant1;
        last_grant <= grant1;
        sub_q      <= grant1 ? req1_sub  : req0_sub;
        srca_q     <= grant1 ? req1_srca : req0_srca;
        srcb_q     <= grant1 ? req1_srcb : req0_srcb;
        tag_q      <= grant1 ? req1_tag  : req0_tag;
        cnt        <= CNT_INIT;
      end
      if (state == FPD_SCHED_EXEC) begin
        if (cnt != 3'd0) cnt   <= cnt - 3'd1;
        else             res_q <= add_dst;
      end
    end
  end

  FpuFpD_Add u_add (
    .enable (state == FPD_SCHED_EXEC),
    .srca   (srca_q),
    .srcb   (srcb_q),
    .do_sub (sub_q),
    .dst    (add_dst)
  );

  assign req0_ready = grant0 & reset_n;
  assign req1_ready = grant1 & reset_n;
  assign rsp0_valid = (state == FPD_SCHED_RESP) & ~owner;
  assign rsp1_valid = (state == FPD_SCHED_RESP) & owner;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_tag   = tag_q;
  assign rsp1_tag   = tag_q;
  assign busy       = (state != FPD_SCHED_IDLE);

endmodule

// File: tb/tb_fpu_fpd_add_sched.sv
// tb/tb_fpu_fpd_add_sched.sv - scoreboard bench for the shared double adder scheduler
module tb_fpu_fpd_add_sched;

  localparam int LAT  = 2;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
  logic [63:0]     req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [63:0]     rsp0_data, rsp1_data;
  logic [TAGW-1:0] rsp0_tag, rsp1_tag;

  fpu_fpd_add_sched #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              port;
    logic [63:0]     data;
    logic [TAGW-1:0] tag;
    int              hs_cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              order_q[$];
  int              cyc = 0;
  int              n_tests = 0;
  int              n_fail = 0;
  int              rsp_hs_cyc[2];
  bit              prev_v[2];
  logic [63:0]     held_data[2];
  logic [TAGW-1:0] held_tag[2];
  bit              hold0 = 1'b0;
  bit              rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: IEEE double arithmetic, with any subnormal or signed-zero result reported as +0.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    real         r;
    logic [63:0] bits;
    r    = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    bits = $realtobits(r);
    if (bits[62:52] == 11'd0) bits = 64'd0;
    return bits;
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'($urandom_range(990, 1060));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  initial begin
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp0_ready = !hold0 && (!rnd_rdy || $urandom_range(0, 2) != 0);
      rsp1_ready = !rnd_rdy || $urandom_range(0, 2) != 0;
    end
  end

  task automatic mon_port(input int p, input logic v, input logic r,
                          input logic [63:0] d, input logic [TAGW-1:0] t);
    if (v && !prev_v[p]) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("rsp_port", 64'(exp_q[0].port), 64'(p));
        check("rsp_latency", 64'(cyc - exp_q[0].hs_cyc), 64'(LAT + 1));
      end
    end
    if (v && prev_v[p]) begin
      check("rsp_hold_data", d, held_data[p]);
      check("rsp_hold_tag", 64'(t), 64'(held_tag[p]));
    end
    if (v && r && exp_q.size() != 0) begin
      check("rsp_data", d, exp_q[0].data);
      check("rsp_tag", 64'(t), 64'(exp_q[0].tag));
      void'(exp_q.pop_front());
      rsp_hs_cyc[p] = cyc;
    end
    prev_v[p]    = v && !r;
    held_data[p] = d;
    held_tag[p]  = t;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
      end else begin
        check("rsp_valid_onehot", 64'(rsp0_valid & rsp1_valid), 64'(0));
        check("ready_while_busy", 64'((req0_ready | req1_ready) & busy), 64'(0));
        check("ready_onehot", 64'(req0_ready & req1_ready), 64'(0));
        mon_port(0, rsp0_valid, rsp0_ready, rsp0_data, rsp0_tag);
        mon_port(1, rsp1_valid, rsp1_ready, rsp1_data, rsp1_tag);
      end
    end
  end

  task automatic do_req(input int p, input logic sub, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAGW-1:0] tag, output int acc);
    bit got = 1'b0;
    acc = -1;
    @(posedge clk);
    #1;
    if (p == 0) begin
      req0_sub = sub; req0_srca = a; req0_srcb = b; req0_tag = tag; req0_valid = 1'b1;
    end else begin
      req1_sub = sub; req1_srca = a; req1_srcb = b; req1_tag = tag; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (reset_n && (p == 0 ? req0_ready : req1_ready)) begin
        exp_q.push_back('{p, model(a, b, sub), tag, cyc});
        order_q.push_back(p);
        acc = cyc;
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (!got) check("req_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 64'(0), 64'(1));
  endtask

  int          d0, d1, acc1;
  logic [63:0] a0, b0, a1, b1;
  bit          en0, en1, s0, s1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_sub = 1'b0; req0_srca = '0; req0_srcb = '0; req0_tag = '0;
    req1_valid = 1'b1; req1_sub = 1'b0; req1_srca = '0; req1_srcb = '0; req1_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req0_ready", 64'(req0_ready), 64'(0));
    check("reset_req1_ready", 64'(req1_ready), 64'(0));
    check("reset_rsp0_valid", 64'(rsp0_valid), 64'(0));
    check("reset_rsp1_valid", 64'(rsp1_valid), 64'(0));
    check("reset_rsp0_data", rsp0_data, 64'(0));
    check("reset_rsp1_tag", 64'(rsp1_tag), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // tie out of reset goes to req0, then alternates
    fork
      do_req(0, 1'b0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd1, d0);
      do_req(1, 1'b0, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd2, d1);
    join
    fork
      do_req(0, 1'b1, 64'h4010_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd3, d0);
      do_req(1, 1'b1, 64'h4014_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd4, d1);
    join
    wait_idle();
    check("arb_count", 64'(order_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check("arb_order", 64'(order_q[i]), 64'(i % 2));

    do_req(0, 1'b0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd5, d0);
    wait_idle();
    do_req(1, 1'b1, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'd6, d1);
    wait_idle();
    do_req(1, 1'b1, 64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd7, d1);
    wait_idle();
    do_req(0, 1'b0, 64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 4'd8, d0);
    wait_idle();
    do_req(1, 1'b0, 64'hFFE0_0000_0000_0000, 64'hFFE0_0000_0000_0000, 4'd9, d1);
    wait_idle();

    // response back-pressure: req1 must wait until the cycle after the rsp0 handshake
    hold0 = 1'b1;
    fork
      do_req(0, 1'b0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'hA, d0);
      begin
        repeat (2) @(posedge clk);
        do_req(1, 1'b0, 64'h3FF8_0000_0000_0000, 64'h3FF8_0000_0000_0000, 4'hB, acc1);
      end
      begin
        for (int i = 0; i < 50 && !rsp0_valid; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        hold0 = 1'b0;
      end
    join
    wait_idle();
    check("req1_accept_after_rsp0", 64'(acc1), 64'(rsp_hs_cyc[0] + 1));

    // reset while in EXEC abandons the operation
    do_req(0, 1'b0, 64'h4020_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'hC, d0);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_rsp0_valid", 64'(rsp0_valid), 64'(0));
    check("midreset_rsp1_valid", 64'(rsp1_valid), 64'(0));
    check("midreset_rsp0_data", rsp0_data, 64'(0));
    check("midreset_rsp0_tag", 64'(rsp0_tag), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    do_req(0, 1'b0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'hD, d0);
    wait_idle();

    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a0 = rand_fp(); a1 = rand_fp();
      b0 = ($urandom_range(0, 3) == 0) ? a0 : rand_fp();
      b1 = ($urandom_range(0, 3) == 0) ? a1 : rand_fp();
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      en0 = 1'($urandom_range(0, 1));
      en1 = !en0 || ($urandom_range(0, 1) == 1);
      fork
        begin if (en0) do_req(0, s0, a0, b0, 4'($urandom), d0); end
        begin if (en1) do_req(1, s1, a1, b1, 4'($urandom), d1); end
      join
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
